logic_unit_pipe: RTL and testbench
==================================

LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8, which sets the operand and result width in bits (minimum 1).
REQ-002 The block SHALL take parameter CNT_W, default 16, which sets the accepted-transaction counter width in bits (minimum 1).
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  single rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  operand/op bundle valid.
REQ-007 in_ready  output  1  block can accept a bundle this cycle.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B, used only when acc_mode=0.
REQ-010 op  input  3  operation select.
REQ-011 acc_mode  input  1  when 1, operand B is the internal accumulator.
REQ-012 clear  input  1  synchronous accumulator clear.
REQ-013 out_valid  output  1  result register holds an unconsumed result.
REQ-014 out_ready  input  1  downstream accepts the result.
REQ-015 result  output  WIDTH  registered result.
REQ-016 zero  output  1  result == 0, registered together with result.
REQ-017 ones  output  1  result is all ones, registered together with result.
REQ-018 count  output  CNT_W  number of accepted bundles, saturating.

Function
REQ-019 Operations SHALL be bitwise over WIDTH bits: 000 ~A; 001 A; 010 ~(A^B); 011 A^B; 100 A|B; 101 ~(A|B); 110 A&B; 111 ~(A&B).
REQ-020 Effective B SHALL be: b when acc_mode=0; 0 when acc_mode=1 and clear=1; otherwise the accumulator.
REQ-021 A bundle SHALL be accepted when in_valid && in_ready.
REQ-022 in_ready SHALL equal (!out_valid || out_ready), so that a full-throughput stream is accepted every cycle with no bubble.
REQ-023 On acceptance, result, zero and ones SHALL load the computed value at the next rising edge, and out_valid SHALL be 1 at that edge (latency 1 cycle).
REQ-024 When out_valid && out_ready && !accept, out_valid SHALL clear at the next edge, and result SHALL hold its last value.
REQ-025 While out_valid && !out_ready, result, zero, ones and out_valid SHALL remain stable, and no bundle SHALL be accepted.
REQ-026 The accumulator (internal, WIDTH bits) SHALL load the computed result on every accepted bundle, regardless of acc_mode.
REQ-027 clear=1 with no acceptance SHALL set the accumulator to 0 at the next edge.
REQ-028 clear=1 together with an acceptance SHALL make the accumulator load the computed result, which per REQ-020 uses B=0 when acc_mode=1.
REQ-029 count SHALL increment by 1 per accepted bundle and saturate at 2^CNT_W-1; clear SHALL NOT affect count.
REQ-030 Inputs a, b, op and acc_mode SHALL be ignored on cycles without acceptance.

Reset
REQ-031 While rst_n=0, the block SHALL immediately and asynchronously force out_valid=0, result=0, zero=1, ones=0, accumulator=0 and count=0.
REQ-032 While rst_n=0, in_ready SHALL be 1, and no acceptance SHALL occur until the first rising edge after rst_n rises.
REQ-033 Reset asserted mid-operation SHALL discard any pending result with no partial state retained.

Verification (WIDTH=8, CNT_W=2 unless noted)
REQ-034 Reset: assert rst_n=0 mid-cycle -> out_valid=0, result=0x00, zero=1, count=0 immediately, without waiting for a clock edge.
REQ-035 Truth table: with out_ready=1, a=0xF0 and b=0xCC, apply op 000..111 on consecutive cycles -> results 0x0F, 0xF0, 0xC3, 0x3C, 0xFC, 0x03, 0xC0, 0x3F, each one cycle after acceptance; additionally op=000 with a=0xFF -> 0x00 with zero=1.
REQ-036 Backpressure: out_ready=0 after one accept of 0x3C while in_valid stays 1 with new data -> in_ready=0 and result holds 0x3C; raising out_ready -> the next result appears one cycle later with no bundle lost or duplicated.
REQ-037 Accumulate: pulse clear=1 with no accept, then apply acc_mode=1, op=100 with a=0x01, then a=0x80, then op=011 with a=0xFF -> results 0x01, 0x81, 0x7E.
REQ-038 Clear with accept: accumulator=0x81, then apply acc_mode=1, op=100, a=0x10, clear=1 -> result 0x10 and accumulator 0x10.
REQ-039 Counter: perform 5 accepts with CNT_W=2 -> count reads 1, 2, 3, 3, 3; a clear pulse leaves count at 3.

Source files
------------

// File: rtl/logic_unit_pipe.sv
// Single-stage bitwise logic unit with valid/ready handshake, an internal
// accumulator usable as operand B, and a saturating accepted-bundle counter.
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc_mode,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ones,
  output logic [CNT_W-1:0] count
);

  typedef enum logic [2:0] {
    OP_NOT_A = 3'b000,
    OP_PASS_A = 3'b001,
    OP_XNOR  = 3'b010,
    OP_XOR   = 3'b011,
    OP_OR    = 3'b100,
    OP_NOR   = 3'b101,
    OP_AND   = 3'b110,
    OP_NAND  = 3'b111
  } op_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q,    result_d;
  logic             zero_q,      zero_d;
  logic             ones_q,      ones_d;
  logic [WIDTH-1:0] acc_q,       acc_d;
  logic [CNT_W-1:0] count_q,     count_d;

  logic             accept;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] calc;

  // A held result only blocks input while downstream is stalled, so a
  // continuous stream moves one bundle per cycle with no bubble.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    b_eff = b;
    if (acc_mode) begin
      b_eff = clear ? '0 : acc_q;
    end
  end

  always_comb begin
    calc = '0;
    unique case (op_e'(op))
      OP_NOT_A:  calc = ~a;
      OP_PASS_A: calc = a;
      OP_XNOR:   calc = ~(a ^ b_eff);
      OP_XOR:    calc = a ^ b_eff;
      OP_OR:     calc = a | b_eff;
      OP_NOR:    calc = ~(a | b_eff);
      OP_AND:    calc = a & b_eff;
      OP_NAND:   calc = ~(a & b_eff);
      default:   calc = '0;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    ones_d      = ones_q;
    acc_d       = acc_q;
    count_d     = count_q;

    if (accept) begin
      out_valid_d = 1'b1;
      result_d    = calc;
      zero_d      = (calc == '0);
      ones_d      = (calc == '1);
      acc_d       = calc;
      if (count_q != CNT_MAX) begin
        count_d = count_q + 1'b1;
      end
    end else begin
      if (out_ready) begin
        out_valid_d = 1'b0;
      end
      // A clear that coincides with an accept is already folded into b_eff.
      if (clear) begin
        acc_d = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      ones_q      <= 1'b0;
      acc_q       <= '0;
      count_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      ones_q      <= ones_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign ones      = ones_q;
  assign count     = count_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: a driver predicts each accepted result
// into a queue, and an independent monitor compares whatever the DUT presents.
module tb_logic_unit_pipe;

  localparam int W  = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [W-1:0]  a, b;
  logic [2:0]    op;
  logic          acc_mode, clear;
  logic          out_valid, out_ready;
  logic [W-1:0]  result;
  logic          zero, ones;
  logic [CW-1:0] count;

  logic_unit_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .acc_mode(acc_mode), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .ones(ones), .count(count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] seen[$];

  // Behavioural model state
  bit           m_ov;
  logic [W-1:0] m_acc;
  int           m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Each op is a two-input boolean function applied to every bit position.
  function automatic logic [W-1:0] ref_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) begin
      bit p, q;
      p = x[i];
      q = y[i];
      case (o)
        3'd0: r[i] = !p;
        3'd1: r[i] = p;
        3'd2: r[i] = (p == q);
        3'd3: r[i] = (p != q);
        3'd4: r[i] = p || q;
        3'd5: r[i] = !(p || q);
        3'd6: r[i] = p && q;
        default: r[i] = !(p && q);
      endcase
    end
    return r;
  endfunction

  // Called just after a rising edge; drives one cycle and returns just after the next.
  task automatic cycle(input bit v, input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic [2:0] top, input bit am, input bit clr, input bit ordy);
    bit rdy;
    logic [W-1:0] beff, r;
    in_valid = v; a = ta; b = tb; op = top; acc_mode = am; clear = clr; out_ready = ordy;
    @(negedge clk);
    rdy = !m_ov || ordy;
    check("out_valid", out_valid, m_ov);
    check("in_ready", in_ready, rdy);
    check("count", count, m_cnt);
    if (v && rdy) begin
      beff = !am ? tb : (clr ? '0 : m_acc);
      r = ref_op(top, ta, beff);
      exp_q.push_back(r);
      m_acc = r;
      if (m_cnt < (1 << CW) - 1) m_cnt++;
      m_ov = 1'b1;
    end else begin
      if (clr) m_acc = '0;
      if (ordy) m_ov = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, $urandom, $urandom, $urandom, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic check_seen(input string name, input logic [W-1:0] want[$]);
    check({name, "_count"}, seen.size(), want.size());
    for (int i = 0; i < want.size() && i < seen.size(); i++)
      check($sformatf("%s_%0d", name, i), seen[i], want[i]);
    seen.delete();
  endtask

  // Monitor: the held result must match the oldest prediction every cycle it is
  // presented; it is retired only when downstream takes it.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", result, 32'hdead);
      end else begin
        check("result", result, exp_q[0]);
        check("zero", zero, exp_q[0] == '0);
        check("ones", ones, exp_q[0] == '1);
        if (out_ready) begin
          seen.push_back(result);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [W-1:0] want[$];
    logic [2:0]   cnt_seq[5];
    cnt_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    rst_n = 1'b0;
    in_valid = 0; a = 0; b = 0; op = 0; acc_mode = 0; clear = 0; out_ready = 0;
    m_ov = 0; m_acc = '0; m_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_zero", zero, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Truth table, full throughput
    for (int o = 0; o < 8; o++) cycle(1'b1, 8'hF0, 8'hCC, 3'(o), 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'hFF, 8'hCC, 3'd0, 1'b0, 1'b0, 1'b1);
    idle(2);
    want = '{8'h0F, 8'hF0, 8'hC3, 8'h3C, 8'hFC, 8'h03, 8'hC0, 8'h3F, 8'h00};
    check_seen("truth", want);

    // Backpressure
    cycle(1'b1, 8'hF0, 8'hCC, 3'd3, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'hF0, 8'hCC, 3'd4, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'hF0, 8'hCC, 3'd4, 1'b0, 1'b0, 1'b0);
    check("bp_hold_result", result, 8'h3C);
    check("bp_in_ready", in_ready, 0);
    cycle(1'b1, 8'hF0, 8'hCC, 3'd4, 1'b0, 1'b0, 1'b1);
    check("bp_next_result", result, 8'hFC);
    idle(2);
    want = '{8'h3C, 8'hFC};
    check_seen("bp", want);

    // Accumulate
    cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 8'h01, 8'h55, 3'd4, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 8'h80, 8'h55, 3'd4, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 8'hFF, 8'h55, 3'd3, 1'b1, 1'b0, 1'b1);
    idle(2);
    want = '{8'h01, 8'h81, 8'h7E};
    check_seen("accum", want);

    // Clear together with accept: accumulator becomes 0x10, read back as 0|acc
    cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 8'h01, 8'h00, 3'd4, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 8'h80, 8'h00, 3'd4, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 8'h10, 8'h00, 3'd4, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 8'h00, 8'h00, 3'd4, 1'b1, 1'b0, 1'b1);
    idle(2);
    want = '{8'h01, 8'h81, 8'h10, 8'h10};
    check_seen("clr_acc", want);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, W'($urandom), W'($urandom), 3'($urandom),
            1'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
    end
    idle(3);
    check("drain_empty", exp_q.size(), 0);
    seen.delete();

    // Asynchronous reset mid-cycle with a result pending
    cycle(1'b1, 8'h5A, 8'h0F, 3'd3, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_result", result, 0);
    check("arst_zero", zero, 1);
    check("arst_ones", ones, 0);
    check("arst_count", count, 0);
    check("arst_in_ready", in_ready, 1);
    exp_q.delete();
    m_ov = 0; m_acc = '0; m_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Counter saturation (CNT_W=2); clear leaves count alone
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, W'($urandom), W'($urandom), 3'($urandom), 1'b0, 1'b0, 1'b1);
      check($sformatf("cnt_%0d", i), count, cnt_seq[i]);
    end
    cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b1, 1'b1);
    check("cnt_after_clear", count, 3);
    idle(2);
    check("final_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
